demux8_reg: RTL
===============

# demux8_reg

Registered 1-to-8 write distributor: the write-side counterpart of the CPU's 8-way 32-bit result selector. It routes one 32-bit word into one of eight holding slots chosen by a 3-bit select. It tracks per-slot valid flags that a consumer clears, and reports overwrites of unconsumed data. It sits between a single producer (datapath write-back or bus) and up to eight downstream consumers that each read a fixed slot.

## Interface
Parameters: none; data width fixed at 32, slot count fixed at 8.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- d  input  32  write data
- s  input  3  slot select; s=0 targets r0, s=1 targets r1, … s=7 targets r7
- we  input  1  write enable, sampled at rising edge of clk
- take  input  8  per-slot consume strobe; take[i]=1 clears vld[i]
- clr  input  1  synchronous clear of all valid flags and ovf
- r0 … r7  output  32 each  slot holding registers
- vld  output  8  per-slot valid flags
- wr_ack  output  1  one-cycle pulse after an accepted write
- wr_sel  output  3  slot index of the most recent accepted write
- ovf  output  1  sticky overwrite flag; only present when DEMUX8_OVF_EN is defined, otherwise constant 0

## Operation
- Write: when we=1 at an edge, r[s] ← d and vld[s] ← 1. wr_sel ← s and wr_ack ← 1. The other seven slots keep their data.
- No write: wr_ack ← 0, and wr_sel holds its value.
- Consume: for each i with take[i]=1, vld[i] ← 0. Slot data r[i] is not cleared.
- Write and take on the same slot in the same edge: the write wins, so vld[s] stays 1 with the new data.
- Write to slot a while take hits slot b≠a: both take effect.
- take on a slot that is already invalid: no effect and no error.
- Overwrite: a write to a slot whose vld is 1 before the edge, and which is not being taken on that same edge, sets ovf ← 1. ovf stays 1 until clr or rst.
- clr=1:
  - vld ← 0 and ovf ← 0 for all slots.
  - A write on the same edge is still accepted: r[s] is written, vld[s] ← 1 and wr_ack ← 1. The write overrides the clear for that slot only.
  - r0–r7 and wr_sel are not affected by clr.
- Priority per slot for vld: write > clr > take.
- Select decoding is full: all 8 values of s are legal, and there is no default or illegal case.

## Timing
- Reset (rst=1, asynchronous): r0–r7 = 0, vld = 0, wr_ack = 0, wr_sel = 0, ovf = 0. All outputs are forced immediately and held while rst is high.
- Reset deasserted: the first edge with rst=0 is a normal operating edge.
- Reset mid-write: a write whose edge coincides with rst high is discarded.
- Write latency: 1 cycle. Data presented with we=1 before edge k is visible on r[s] and vld[s] right after edge k.
- wr_ack is high for exactly the cycle following edge k. Back-to-back writes keep wr_ack high continuously.
- take latency: 1 cycle. The vld bit falls after the edge at which take was sampled.
- Throughput: one write per cycle, plus any number of simultaneous takes.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro: DEMUX8_OVF_EN.
- Defined:
  - The ovf register and overwrite-detection logic are built.
  - ovf behaves as described under Operation.
- Undefined:
  - The ovf port still exists but is tied to 1'b0.
  - No detection logic is synthesized.
  - Every other behaviour is identical.

## Test plan
- Reset: assert rst mid-cycle with slots loaded → all outputs read 0 immediately, before the next edge. After release, vld=8'h00 and wr_ack=0.
- Sweep: write d=32'h1000_0000+i with s=i for i=0..7 on consecutive edges.
  - Each slot ri = 32'h1000_0000+i.
  - vld ends at 8'hFF.
  - wr_ack stays high for 8 cycles; wr_sel tracks i.
- Consume: with vld=8'hFF, pulse take=8'b0000_0101 → vld=8'hFA, and r0/r2 data is unchanged.
- Collision: vld[3]=1, then in the same cycle we=1, s=3, d=32'hDEAD_BEEF and take[3]=1.
  - r3=32'hDEAD_BEEF and vld[3]=1.
  - ovf=0, because the slot is being taken on that edge.
- Overflow (DEMUX8_OVF_EN defined):
  - With vld[5]=1, write s=5 → ovf=1, and it stays 1 across 10 idle cycles.
  - clr=1 → ovf=0 and vld=0.
  - Rebuilt without the macro, the same stimulus leaves ovf=0 throughout.
- clr with simultaneous write: vld=8'hFF, then clr=1 with we=1, s=6 → vld=8'h40 and wr_ack=1.

Source files
------------

// File: rtl/demux8_reg_if.sv
// demux8_reg_if: producer/consumer bundle for the registered 1-to-8 write distributor.
// The master modport belongs to the producer side that drives write and consume
// strobes; the slave modport belongs to demux8_reg, which drives the slot outputs.
interface demux8_reg_if;
    logic [31:0] d;
    logic [2:0]  s;
    logic        we;
    logic [7:0]  take;
    logic        clr;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [31:0] r4;
    logic [31:0] r5;
    logic [31:0] r6;
    logic [31:0] r7;
    logic [7:0]  vld;
    logic        wr_ack;
    logic [2:0]  wr_sel;
    logic        ovf;

    modport master (
        output d, s, we, take, clr,
        input  r0, r1, r2, r3, r4, r5, r6, r7, vld, wr_ack, wr_sel, ovf
    );

    modport slave (
        input  d, s, we, take, clr,
        output r0, r1, r2, r3, r4, r5, r6, r7, vld, wr_ack, wr_sel, ovf
    );
endinterface

// File: rtl/demux8_reg.sv
// demux8_reg: registered 1-to-8 write distributor with per-slot valid flags.
// One 32-bit word per cycle is routed into the slot chosen by s; consumers
// clear their slot's valid flag with take; clr drops all flags at once.
// Optional feature macro: DEMUX8_OVF_EN builds the sticky overwrite flag ovf.
// Without it, ovf is tied low and no detection logic exists.
module demux8_reg (
    input  logic         clk,
    input  logic         rst,
    demux8_reg_if.slave  bus
);

    logic [31:0] r_slot [8];
    logic [7:0]  r_vld;
    logic        r_wrAck;
    logic [2:0]  r_wrSel;
    logic [7:0]  w_wrDec;
    logic [7:0]  w_vldNext;

    // One-hot decode of the write target; all zeros when no write is requested.
    // A write sets its slot's flag regardless of clr or take, so it sits on top
    // of whatever survives the clear/consume step.
    always_comb begin
        w_wrDec   = 8'h00;
        w_vldNext = 8'h00;
        if (bus.we) begin
            w_wrDec = 8'h01 << bus.s;
        end
        if (bus.clr) begin
            w_vldNext = w_wrDec;
        end else begin
            w_vldNext = w_wrDec | (r_vld & ~bus.take);
        end
    end

    // Slot data only changes on a write to that slot; consume and clear leave data intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_wrDec[i]) begin
                    r_slot[i] <= bus.d;
                end
            end
        end
    end

    // Valid flags, write acknowledge pulse and last-written slot index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= 8'h00;
            r_wrAck <= 1'b0;
            r_wrSel <= 3'd0;
        end else begin
            r_vld   <= w_vldNext;
            r_wrAck <= bus.we;
            if (bus.we) begin
                r_wrSel <= bus.s;
            end
        end
    end

`ifdef DEMUX8_OVF_EN
    logic r_ovf;
    logic w_ovfHit;

    // An overwrite is a write landing on a still-valid slot that is not being
    // consumed on the same edge.
    always_comb begin
        w_ovfHit = |(w_wrDec & r_vld & ~bus.take);
    end

    // Sticky overwrite flag; only clr or reset drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.clr) begin
            r_ovf <= 1'b0;
        end else if (w_ovfHit) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.r0     = r_slot[0];
    assign bus.r1     = r_slot[1];
    assign bus.r2     = r_slot[2];
    assign bus.r3     = r_slot[3];
    assign bus.r4     = r_slot[4];
    assign bus.r5     = r_slot[5];
    assign bus.r6     = r_slot[6];
    assign bus.r7     = r_slot[7];
    assign bus.vld    = r_vld;
    assign bus.wr_ack = r_wrAck;
    assign bus.wr_sel = r_wrSel;

endmodule
